// File: rtl/vm_vend_if.sv
// Handshake bundle between the vending-machine core, the actuators and the
// vend sequencer. The master side is the core plus actuators; the slave side
// is the sequencer itself.
interface vm_vend_if;
  logic       req;
  logic       refund;
  logic [3:0] drink;
  logic [3:0] change;
  logic       busy;
  logic [3:0] motor_sel;
  logic       motor_go;
  logic       motor_done;
  logic       coin2_go;
  logic       coin1_go;
  logic       coin_ack;
  logic [3:0] paid;
  logic       done;
  logic       fault;

  modport master (
    output req, refund, drink, change, motor_done, coin_ack,
    input  busy, motor_sel, motor_go, coin2_go, coin1_go, paid, done, fault
  );

  modport slave (
    input  req, refund, drink, change, motor_done, coin_ack,
    output busy, motor_sel, motor_go, coin2_go, coin1_go, paid, done, fault
  );
endinterface

// File: rtl/vm_vend_seq.sv
// Vend sequencer: latches a purchase/refund, pulses the product motor and
// waits for its completion, then pays change one coin at a time (2-unit coins
// first, then a 1-unit coin) with a per-handshake timeout. A motor timeout is
// recorded as a fault but change is still paid; a coin timeout parks the block
// in HALT until reset.
module vm_vend_seq #(
  parameter int unsigned TIMEOUT = 15  // 1..255, cycles per handshake wait
) (
  input  logic     clk,
  input  logic     rst,   // asynchronous, active-low
  vm_vend_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISP,
    S_WAITM,
    S_PAY,
    S_WAITC,
    S_FIN,
    S_HALT
  } state_t;

  // The timer counts 0..TIMEOUT-1; the wait ends on the edge that sees the
  // last value, which makes a wait last exactly TIMEOUT cycles.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] drink_q;
  logic [3:0] remaining;
  logic [3:0] paid_q;
  logic [7:0] timer;
  logic       coin2_sel;
  logic       fault_q;
  logic [3:0] coin_val;
  logic       timer_exp;

  assign coin_val  = coin2_sel ? 4'd2 : 4'd1;
  assign timer_exp = (timer == TIMER_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // active-low clear, so every flop sees pre-edge values and reset needs no clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decision.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.req)         state_nxt = (bus.drink != 4'd0) ? S_DISP : S_PAY;
        else if (bus.refund) state_nxt = S_PAY;
      end
      S_DISP:  state_nxt = S_WAITM;
      S_WAITM: if (bus.motor_done || timer_exp) state_nxt = S_PAY;
      S_PAY:   state_nxt = (remaining == 4'd0) ? S_FIN : S_WAITC;
      S_WAITC: begin
        if (bus.coin_ack)   state_nxt = S_PAY;
        else if (timer_exp) state_nxt = S_HALT;
      end
      S_FIN:   state_nxt = S_IDLE;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Transaction datapath: latched request, handshake timer, coin accounting
  // and the sticky fault flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drink_q   <= 4'd0;
      remaining <= 4'd0;
      paid_q    <= 4'd0;
      timer     <= 8'd0;
      coin2_sel <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            drink_q   <= bus.drink;
            remaining <= bus.change;
            paid_q    <= 4'd0;
          end else if (bus.refund) begin
            drink_q   <= 4'd0;
            remaining <= bus.change;
            paid_q    <= 4'd0;
          end
        end
        S_DISP: timer <= 8'd0;
        S_WAITM: begin
          if (!bus.motor_done) begin
            if (timer_exp) fault_q <= 1'b1;
            else           timer   <= timer + 8'd1;
          end
        end
        S_PAY: begin
          timer     <= 8'd0;
          coin2_sel <= (remaining >= 4'd2);
        end
        S_WAITC: begin
          if (bus.coin_ack) begin
            remaining <= remaining - coin_val;
            paid_q    <= paid_q + coin_val;
          end else if (timer_exp) begin
            fault_q <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the current state and latched data.
  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.motor_go  = 1'b0;
    bus.motor_sel = 4'd0;
    bus.coin2_go  = 1'b0;
    bus.coin1_go  = 1'b0;
    bus.done      = 1'b0;
    bus.paid      = paid_q;
    bus.fault     = fault_q;
    case (state)
      S_DISP: begin
        bus.motor_go  = 1'b1;
        bus.motor_sel = drink_q;
      end
      S_WAITC: begin
        bus.coin2_go = coin2_sel;
        bus.coin1_go = !coin2_sel;
      end
      S_FIN:   bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vm_vend_seq.sv
// Directed bench for vm_vend_seq: background motor/hopper responders, a
// negedge monitor logging pulses and coin sequence, and directed scenarios
// with hand-computed expectations.
module tb_vm_vend_seq;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vm_vend_if bus();

  vm_vend_seq #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Responder knobs (written only by the stimulus process).
  bit motor_en  = 1'b1;
  bit coin_en   = 1'b1;
  int motor_dly = 3;
  int coin_dly  = 2;

  // Motor model: pulse motor_done motor_dly cycles after seeing motor_go.
  bit m_armed = 1'b0;
  int m_cnt   = 0;
  always @(negedge clk) begin
    bus.motor_done = 1'b0;
    if (!rst) m_armed = 1'b0;
    if (m_armed) begin
      m_cnt++;
      if (m_cnt == motor_dly) begin
        bus.motor_done = 1'b1;
        m_armed = 1'b0;
      end
    end
    if (bus.motor_go && motor_en) begin
      m_armed = 1'b1;
      m_cnt   = 0;
    end
  end

  // Hopper model: acknowledge a coin request after coin_dly cycles of go.
  int c_cnt = 0;
  always @(negedge clk) begin
    if (coin_en && (bus.coin2_go || bus.coin1_go)) begin
      c_cnt++;
      bus.coin_ack = (c_cnt == coin_dly);
    end else begin
      c_cnt = 0;
      bus.coin_ack = 1'b0;
    end
  end

  // Monitor: pulse counts, coin sequence and output sanity.
  int motor_cnt = 0;
  int done_cnt  = 0;
  int go_hi     = 0;
  int sel_err   = 0;
  int both_err  = 0;
  int coin_n    = 0;
  int coin_log [64];
  bit prev1 = 1'b0;
  bit prev2 = 1'b0;
  always @(negedge clk) begin
    if (bus.motor_go) motor_cnt++;
    else if (bus.motor_sel != 4'd0) sel_err++;
    if (bus.done) done_cnt++;
    if (bus.coin2_go || bus.coin1_go) go_hi++;
    if (bus.coin2_go && bus.coin1_go) both_err++;
    if (coin_n < 64) begin
      if (bus.coin2_go && !prev2) begin coin_log[coin_n] = 2; coin_n++; end
      else if (bus.coin1_go && !prev1) begin coin_log[coin_n] = 1; coin_n++; end
    end
    prev2 = bus.coin2_go;
    prev1 = bus.coin1_go;
  end

  function automatic logic [13:0] outs();
    return {bus.busy, bus.motor_go, bus.motor_sel, bus.coin2_go, bus.coin1_go,
            bus.paid, bus.done, bus.fault};
  endfunction

  // Present a request for exactly one rising edge; returns at the negedge
  // just after the IDLE exit edge.
  task automatic start(input bit r, input bit f, input logic [3:0] d, input logic [3:0] c);
    @(negedge clk);
    bus.req = r; bus.refund = f; bus.drink = d; bus.change = c;
    @(negedge clk);
    bus.req = 1'b0; bus.refund = 1'b0; bus.drink = 4'd0; bus.change = 4'd0;
  endtask

  // Wait (bounded) for a done pulse beyond base; n returns negedges waited.
  task automatic wait_done(input string tag, input int base, output int n);
    n = 0;
    while (done_cnt == base && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, done_cnt != base, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mb, db, cb, gb, n;
    rst = 1'b0;
    bus.req = 1'b0; bus.refund = 1'b0; bus.drink = 4'd0; bus.change = 4'd0;
    #12;
    check("reset_outs", outs(), 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    check("idle_outs", outs(), 0);

    // Normal vend: drink 3, change 5 -> coins 2,2,1.
    mb = motor_cnt; db = done_cnt; cb = coin_n;
    start(1, 0, 4'd3, 4'd5);
    check("t1_motor_go", bus.motor_go, 1);
    check("t1_motor_sel", bus.motor_sel, 3);
    check("t1_busy", bus.busy, 1);
    wait_done("t1", db, n);
    check("t1_motor_cnt", motor_cnt - mb, 1);
    check("t1_coin_cnt", coin_n - cb, 3);
    check("t1_coin0", coin_log[cb], 2);
    check("t1_coin1", coin_log[cb+1], 2);
    check("t1_coin2", coin_log[cb+2], 1);
    check("t1_paid", bus.paid, 5);
    check("t1_fault", bus.fault, 0);
    @(negedge clk); #1;
    check("t1_done_cnt", done_cnt - db, 1);
    check("t1_busy_end", bus.busy, 0);

    // Refund of 3 -> no motor, coins 2,1.
    mb = motor_cnt; db = done_cnt; cb = coin_n;
    start(0, 1, 4'd9, 4'd3);
    wait_done("t2", db, n);
    check("t2_motor_cnt", motor_cnt - mb, 0);
    check("t2_coin_cnt", coin_n - cb, 2);
    check("t2_coin0", coin_log[cb], 2);
    check("t2_coin1", coin_log[cb+1], 1);
    check("t2_paid", bus.paid, 3);

    // req and refund together, drink 7, change 0: motor, no coins; done
    // arrives 5 negedges after the DISP negedge with motor_dly=3.
    mb = motor_cnt; db = done_cnt; cb = coin_n;
    start(1, 1, 4'd7, 4'd0);
    check("t3_motor_sel", bus.motor_sel, 7);
    wait_done("t3", db, n);
    check("t3_done_latency", n, 5);
    check("t3_motor_cnt", motor_cnt - mb, 1);
    check("t3_coin_cnt", coin_n - cb, 0);
    check("t3_paid", bus.paid, 0);

    // req with drink 0 behaves as a refund of 2.
    mb = motor_cnt; db = done_cnt; cb = coin_n;
    start(1, 0, 4'd0, 4'd2);
    check("t3b_no_motor_go", bus.motor_go, 0);
    wait_done("t3b", db, n);
    check("t3b_motor_cnt", motor_cnt - mb, 0);
    check("t3b_coin_cnt", coin_n - cb, 1);
    check("t3b_coin0", coin_log[cb], 2);
    check("t3b_paid", bus.paid, 2);

    // Motor timeout: fault lands on the 16th edge after the DISP negedge
    // (WAITM entry edge plus TIMEOUT cycles); change is still paid.
    motor_en = 1'b0;
    mb = motor_cnt; db = done_cnt; cb = coin_n;
    start(1, 0, 4'd2, 4'd2);
    n = 0;
    while (!bus.fault && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("t4_fault_latency", n, TIMEOUT + 1);
    wait_done("t4", db, n);
    check("t4_coin_cnt", coin_n - cb, 1);
    check("t4_coin0", coin_log[cb], 2);
    check("t4_paid", bus.paid, 2);
    repeat (3) @(negedge clk);
    #1;
    check("t4_fault_sticky", bus.fault, 1);
    check("t4_busy_end", bus.busy, 0);
    motor_en = 1'b1;

    // Clear the sticky fault.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    check("t5_fault_cleared", bus.fault, 0);

    // Coin timeout: coin2_go held for TIMEOUT cycles, then HALT.
    coin_en = 1'b0;
    mb = motor_cnt; db = done_cnt; gb = go_hi;
    start(0, 1, 4'd0, 4'd4);
    n = 0;
    while (!bus.fault && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("t5_fault", bus.fault, 1);
    check("t5_go_cycles", go_hi - gb, TIMEOUT);
    repeat (5) @(negedge clk);
    #1;
    check("t5_halt_busy", bus.busy, 1);
    check("t5_halt_go", {bus.coin2_go, bus.coin1_go}, 0);
    check("t5_halt_done", done_cnt - db, 0);
    check("t5_halt_paid", bus.paid, 0);
    start(1, 0, 4'd1, 4'd1);
    repeat (3) @(negedge clk);
    #1;
    check("t5_req_ignored", motor_cnt - mb, 0);
    check("t5_still_fault", bus.fault, 1);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("t5_async_reset", outs(), 0);
    @(negedge clk); rst = 1'b1;
    coin_en = 1'b1;

    // Reset mid-payout after the first coin, then a fresh 1-unit vend.
    db = done_cnt;
    start(0, 1, 4'd0, 4'd6);
    n = 0;
    while (bus.paid != 4'd2 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("t6_first_coin", bus.paid, 2);
    #1;
    rst = 1'b0;
    #1;
    check("t6_async_reset", outs(), 0);
    @(negedge clk); rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("t6_abandoned", done_cnt - db, 0);
    check("t6_idle", bus.busy, 0);
    mb = motor_cnt; db = done_cnt; cb = coin_n;
    start(1, 0, 4'd4, 4'd1);
    wait_done("t6", db, n);
    check("t6_motor_cnt", motor_cnt - mb, 1);
    check("t6_coin_cnt", coin_n - cb, 1);
    check("t6_coin0", coin_log[cb], 1);
    check("t6_paid", bus.paid, 1);

    check("sel_only_with_go", sel_err, 0);
    check("coin_go_exclusive", both_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
